ps2_kbd_event_rx: RTL

Parametrised PS/2 keyboard receiver that replaces the fixed 24-bit keycode capture with a fully synchronous, oversampled frame decoder. It checks start, parity and stop bits, and recovers from stalled frames with a timeout. It folds E0 (extended) and F0 (break) prefixes into single key events, which are buffered in an event FIFO with a valid/ready handshake. It sits between the PS/2 pins and the game input controller; key releases are reported as events, not dropped.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_evt_fifo.sv | 50 +++++
 rtl/ps2_kbd_event_rx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard event receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Odd parity across data plus parity bit.
  function automatic logic ps2_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO; head is valid whenever the FIFO is non-empty.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        counter_reset,
  input  logic                        push,
  input  ps2_evt_t                    push_evt,
  input  logic                        pop,
  output ps2_evt_t                    head,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  ps2_evt_t        mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge counter_reset) begin
    if (counter_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_evt;
  end

endmodule

// File: rtl/ps2_kbd_event_rx.sv
// Oversampled PS/2 keyboard frame decoder folding E0/F0 prefixes into key events.
module ps2_kbd_event_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int CLK_FILTER     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        counter_reset,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        evt_ready,
  input  logic                        clear_err,
  output logic                        evt_valid,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_break,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err
);
  localparam int FW = $clog2(CLK_FILTER + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, data_s;
  logic [FW-1:0]          filt_cnt;
  logic                   filt_clk, filt_prev, strobe;

  ps2_state_t state, state_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       par_bit, par_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic       ext_pend, ext_nxt, brk_pend, brk_nxt;
  logic       push, push_nxt, err_nxt;
  ps2_evt_t   push_evt, evt_nxt, head;
  logic       fifo_full, fifo_empty, drop;

  // Input synchronisers and clock deglitch filter; idle bus level is high.
  always_ff @(posedge clk or posedge counter_reset) begin
    if (counter_reset) begin
      clk_sync  <= '1;
      dat_sync  <= '1;
      filt_cnt  <= '0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      filt_prev <= filt_clk;
      if (clk_s != filt_clk) begin
        if (filt_cnt == FW'(CLK_FILTER - 1)) begin
          filt_clk <= clk_s;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = dat_sync[SYNC_STAGES-1];
  assign strobe = filt_prev && !filt_clk;

  always_ff @(posedge clk or posedge counter_reset) begin
    if (counter_reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      push      <= 1'b0;
      push_evt  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= shreg_nxt;
      par_bit   <= par_nxt;
      tmo_cnt   <= tmo_nxt;
      ext_pend  <= ext_nxt;
      brk_pend  <= brk_nxt;
      push      <= push_nxt;
      push_evt  <= evt_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    ext_nxt   = ext_pend;
    brk_nxt   = brk_pend;
    push_nxt  = 1'b0;
    evt_nxt   = push_evt;
    err_nxt   = 1'b0;
    tmo_nxt   = (state == IDLE || strobe) ? '0 : tmo_cnt + 1'b1;

    if (state != IDLE && !strobe && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      // Stalled frame: abandon it along with any prefix it followed.
      state_nxt = IDLE;
      err_nxt   = 1'b1;
      ext_nxt   = 1'b0;
      brk_nxt   = 1'b0;
    end else if (strobe) begin
      case (state)
        IDLE: begin
          if (!data_s) begin
            state_nxt = DATA;
            bit_nxt   = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        DATA: begin
          shreg_nxt = {data_s, shreg[7:1]};
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = data_s;
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (data_s && ps2_parity_ok(shreg, par_bit)) begin
            if (shreg == PS2_EXT_PREFIX) begin
              ext_nxt = 1'b1;
            end else if (shreg == PS2_BRK_PREFIX) begin
              brk_nxt = 1'b1;
            end else begin
              push_nxt = 1'b1;
              evt_nxt  = '{ext: ext_pend, brk: brk_pend, code: shreg};
              ext_nxt  = 1'b0;
              brk_nxt  = 1'b0;
            end
          end else begin
            err_nxt = 1'b1;
            ext_nxt = 1'b0;
            brk_nxt = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  ps2_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .counter_reset(counter_reset),
    .push         (push),
    .push_evt     (push_evt),
    .pop          (evt_ready),
    .head         (head),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;
  assign drop      = push && fifo_full && !(evt_valid && evt_ready);

  // A drop in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clk or posedge counter_reset) begin
    if (counter_reset)  overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_err) overflow <= 1'b0;
  end

endmodule
